// File: rtl/serial_add16_ctrl.sv
// Nibble-serial add/subtract sequencer. One 4-bit carry-lookahead slice is
// stepped across the operands LSB nibble first, with the carry registered between nibbles.

module cla4_ov (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    // Lookahead carries, each expressed directly in terms of g/p/ci
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        cc[0] = ci;
        cc[1] = g[0] | (p[0] & ci);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
        sum   = p ^ cc[3:0];
        co    = cc[4];
        c3    = cc[3];
    end

endmodule

module serial_add16_ctrl #(
    parameter  int unsigned N_NIB = 4,
    localparam int unsigned W     = 4 * N_NIB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         c,
    output logic         v,
    output logic         n,
    output logic         z
);

    localparam int unsigned IW = $clog2(N_NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] a_r, a_r_nx;
    logic [W-1:0] b_r, b_r_nx;
    logic [W-1:0] acc, acc_nx;
    logic         cy, cy_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [W-1:0] s_nx;
    logic         c_nx, v_nx, n_nx, z_nx;
    logic         busy_nx, done_nx;

    logic [3:0]   nib_a, nib_b, nib_sum;
    logic         nib_co, nib_c3;
    logic [W-1:0] full_c;

    // Operand nibble select for the current step
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < int'(N_NIB); k++) begin
            if (idx == IW'(k)) begin
                nib_a = a_r[4*k +: 4];
                nib_b = b_r[4*k +: 4];
            end
        end
    end

    cla4_ov u_slice (
        .a   (nib_a),
        .b   (nib_b),
        .ci  (cy),
        .sum (nib_sum),
        .co  (nib_co),
        .c3  (nib_c3)
    );

    // Completed result: the final nibble comes straight from the slice
    always_comb begin
        full_c = {nib_sum, acc[W-5:0]};
    end

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        a_r_nx   = a_r;
        b_r_nx   = b_r;
        acc_nx   = acc;
        cy_nx    = cy;
        idx_nx   = idx;
        s_nx     = s;
        c_nx     = c;
        v_nx     = v;
        n_nx     = n;
        z_nx     = z;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_r_nx   = a;
                    b_r_nx   = op ? ~b : b;
                    cy_nx    = op;
                    idx_nx   = '0;
                    state_nx = RUN;
                    busy_nx  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < int'(N_NIB); k++) begin
                    if (idx == IW'(k)) acc_nx[4*k +: 4] = nib_sum;
                end
                cy_nx   = nib_co;
                idx_nx  = idx + IW'(1);
                busy_nx = 1'b1;
                if (idx == IW'(N_NIB - 1)) begin
                    s_nx     = full_c;
                    c_nx     = nib_co;
                    v_nx     = nib_c3 ^ nib_co;
                    n_nx     = nib_sum[3];
                    z_nx     = (full_c == '0);
                    idx_nx   = '0;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = DONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            idx   <= '0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
            z     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            a_r   <= a_r_nx;
            b_r   <= b_r_nx;
            acc   <= acc_nx;
            cy    <= cy_nx;
            idx   <= idx_nx;
            s     <= s_nx;
            c     <= c_nx;
            v     <= v_nx;
            n     <= n_nx;
            z     <= z_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Self-checking bench for serial_add16_ctrl: directed vector table, multi-cycle
// corner sequences, and random operations against a plain-arithmetic reference.

module tb_serial_add16_ctrl;

    localparam int N_NIB = 4;
    localparam int W     = 16;
    localparam int LAT   = N_NIB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] s;
    logic         c, v, n, z;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         n;
        logic         z;
    } vec_t;

    serial_add16_ctrl #(.N_NIB(N_NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c     (c),
        .v     (v),
        .n     (n),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Reference: W-bit two's-complement add/sub from plain arithmetic
    function automatic vec_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t r;
        int unsigned ux, uy, full;
        int sx, sy, sr;
        ux = 32'(x);
        uy = 32'(y);
        sx = int'(signed'(x));
        sy = int'(signed'(y));
        r.op = o;
        r.a  = x;
        r.b  = y;
        if (!o) begin
            full = ux + uy;
            r.c  = (full > 32'hFFFF);
            sr   = sx + sy;
        end else begin
            full = ux - uy;
            r.c  = (ux >= uy);
            sr   = sx - sy;
        end
        r.s = full[W-1:0];
        r.v = (sr > 32767) || (sr < -32768);
        r.n = r.s[W-1];
        r.z = (r.s == '0);
        return r;
    endfunction

    task automatic check_result(input string tag, input vec_t e);
        chk({tag, ".s"}, 32'(s), 32'(e.s));
        chk({tag, ".c"}, 32'(c), 32'(e.c));
        chk({tag, ".v"}, 32'(v), 32'(e.v));
        chk({tag, ".n"}, 32'(n), 32'(e.n));
        chk({tag, ".z"}, 32'(z), 32'(e.z));
    endtask

    // One operation; optionally pulse start randomly during RUN
    task automatic do_op(input string tag, input vec_t e, input bit noise);
        int lat, busy_cnt;
        logic [W-1:0] s_before;
        bit leaked;
        @(negedge clk);
        op = e.op; a = e.a; b = e.b; start = 1'b1;
        s_before = s;
        @(posedge clk); #1;
        start = 1'b0;
        op = 1'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0; busy_cnt = 0; leaked = 1'b0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (s !== s_before) leaked = 1'b1;
            if (noise) start = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(LAT));
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(LAT));
        chk({tag, ".no_partial"}, 32'(leaked), 32'(0));
        check_result(tag, e);
        @(posedge clk); #1;
        chk({tag, ".single_done"}, 32'(done), 32'(0));
        chk({tag, ".idle_busy"}, 32'(busy), 32'(0));
    endtask

    vec_t tbl[8];

    initial begin
        int t;
        vec_t e, e2;

        tbl[0] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'h00FF, 16'h0100, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.s", 32'(s), 0);
        chk("reset.flags", 32'({c, v, n, z}), 0);
        chk("reset.busy_done", 32'({busy, done}), 0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Start held high: second op accepted in DONE, inputs changed during RUN
        @(negedge clk);
        op = 1'b0; a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        op = 1'b1; a = 16'h00FF; b = 16'h0100;
        t = 0;
        while (!done && t < 20) begin @(posedge clk); #1; t++; end
        chk("held.first_lat", 32'(t), 32'(LAT));
        chk("held.first_s", 32'(s), 32'h2345);
        chk("held.first_c", 32'(c), 0);
        t = 0;
        @(posedge clk); #1;
        chk("held.busy_after_done", 32'(busy), 1);
        t = 1;
        while (!done && t < 20) begin @(posedge clk); #1; t++; end
        chk("held.spacing", 32'(t), 32'(LAT + 1));
        chk("held.second_s", 32'(s), 32'hFFFF);
        chk("held.second_cvnz", 32'({c, v, n, z}), 32'(4'b0010));
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;

        // Reset in the RUN cycle with idx=2
        @(negedge clk);
        op = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst.s", 32'(s), 0);
        chk("midrst.flags", 32'({c, v, n, z}), 0);
        chk("midrst.busy_done", 32'({busy, done}), 0);
        @(negedge clk); reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst.no_done", 32'(done), 0);
        end
        e = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        do_op("post_reset", e, 1'b0);

        // Random operations with random start pulses during RUN
        for (int i = 0; i < 1000; i++) begin
            e2 = model(1'($urandom), W'($urandom), W'($urandom));
            do_op("rand", e2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
